// File: rtl/tsu_ctrl_pkg.sv
// Shared types for the vernier TSU sequencer: state/error enums, the config
// record and the config validity rule.
package tsu_ctrl_pkg;

    localparam int TSU_DIV_BITS  = 3;
    localparam int TSU_RST_BITS  = 16;
    localparam int TSU_PREC_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_START  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_ERROR  = 3'd5
    } tsu_ctrl_state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CFG    = 2'd1,
        ERR_LOST   = 2'd2,
        ERR_SETTLE = 2'd3
    } tsu_err_e;

    typedef struct packed {
        logic [TSU_DIV_BITS-1:0]  fclk_div;
        logic [TSU_PREC_BITS-1:0] num;
        logic [TSU_PREC_BITS-1:0] denom;
        logic [TSU_RST_BITS-1:0]  timeout;
    } tsu_cfg_t;

    // Divider must be 1 or a nonzero even value; the timeout needs at least
    // two cycles so the watchdog compare against timeout-1 is meaningful.
    function automatic logic tsu_cfg_valid(input tsu_cfg_t cfg);
        logic div_ok;
        div_ok = (cfg.fclk_div == TSU_DIV_BITS'(1)) ||
                 ((cfg.fclk_div != '0) && !cfg.fclk_div[0]);
        return div_ok && (cfg.num != '0) && (cfg.denom != '0) &&
               (cfg.timeout >= TSU_RST_BITS'(2));
    endfunction

endpackage

// File: rtl/tsu_evt_watchdog.sv
// Foreign-clock event watchdog: saturating age counter since the last event
// and a timeout pulse on the cycle the age would reach the limit.
module tsu_evt_watchdog
    import tsu_ctrl_pkg::*;
#(
    parameter int CNT_BITS = TSU_RST_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                arm,
    input  logic                evt,
    input  logic [CNT_BITS-1:0] limit,
    output logic                timeout_p
);

    localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

    logic [CNT_BITS-1:0] age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (clr || evt) begin
            age <= '0;
        end else if (age != '1) begin
            age <= age + ONE;
        end
    end

    // Fires while age == limit-1 so the FSM leaves on the same edge that the
    // age reaches the limit; a coincident event wins and clears the age.
    assign timeout_p = arm && !clr && !evt && (age == limit - ONE);

endmodule

// File: rtl/tsu_vernier_ctrl.sv
// Vernier TSU sequencer: validates config, pulses start, waits for settle and
// supervises the foreign clock. Optional macro TSU_VERNIER_CTRL_AUTORESTART_EN
// re-pulses start on clock loss (up to two retries) instead of erroring.
//
// state  | meaning
// IDLE   | no config applied yet, accepting requests
// CHECK  | validating the captured shadow config (1 cycle)
// START  | o_vernier_start held for START_CYCS cycles, events ignored
// SETTLE | counting in-time events until SETTLE_EVTS arrive
// LOCKED | tracking settled, ready asserted, watching for clock loss
// ERROR  | sticky error code, accepting a new config
module tsu_vernier_ctrl
    import tsu_ctrl_pkg::*;
#(
    parameter int FCLK_DIV_BITS = TSU_DIV_BITS,
    parameter int FCLK_RST_BITS = TSU_RST_BITS,
    parameter int RAT_PREC_BITS = TSU_PREC_BITS,
    parameter int SETTLE_EVTS   = 4,
    parameter int START_CYCS    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic [FCLK_DIV_BITS-1:0] i_cfg_fclk_div,
    input  logic [RAT_PREC_BITS-1:0] i_cfg_num,
    input  logic [RAT_PREC_BITS-1:0] i_cfg_denom,
    input  logic [FCLK_RST_BITS-1:0] i_cfg_timeout,
    input  logic                     i_evt,
    output logic [FCLK_DIV_BITS-1:0] o_fclk_div,
    output logic [RAT_PREC_BITS-1:0] o_num,
    output logic [RAT_PREC_BITS-1:0] o_denom,
    output logic [FCLK_RST_BITS-1:0] o_fclk_rst_cycs,
    output logic                     o_vernier_start,
    output logic                     o_vernier_ready,
    output logic                     o_vernier_error,
    output logic [1:0]               o_err_code
);

    localparam int SC_W = $clog2(START_CYCS + 1);
    localparam int EV_W = $clog2(SETTLE_EVTS + 1);
    localparam logic [SC_W-1:0] START_LOAD = SC_W'(START_CYCS - 1);
    localparam logic [EV_W-1:0] EVT_LAST   = EV_W'(SETTLE_EVTS - 1);
    localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
    localparam logic [EV_W-1:0] EV_ONE     = EV_W'(1);

    tsu_ctrl_state_e state;
    tsu_err_e        err_code;
    tsu_cfg_t        shadow;
    tsu_cfg_t        cfg_in;
    logic [SC_W-1:0] start_cnt;
    logic [EV_W-1:0] evt_cnt;
    logic            accept;
    logic            wd_timeout;
    logic            wd_clr;
    logic            wd_arm;

`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
    localparam logic [1:0] RETRY_MAX = 2'd2;
    logic [1:0] retry_cnt;
`endif

    assign o_cfg_ready = (state == ST_IDLE) || (state == ST_LOCKED) || (state == ST_ERROR);
    assign accept      = i_cfg_valid && o_cfg_ready;
    assign cfg_in      = {i_cfg_fclk_div, i_cfg_num, i_cfg_denom, i_cfg_timeout};
    assign o_err_code  = err_code;
    assign wd_clr      = (state == ST_START);
    assign wd_arm      = (state == ST_SETTLE) || (state == ST_LOCKED);

    tsu_evt_watchdog #(
        .CNT_BITS (FCLK_RST_BITS)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (wd_clr),
        .arm       (wd_arm),
        .evt       (i_evt),
        .limit     (o_fclk_rst_cycs),
        .timeout_p (wd_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            err_code        <= ERR_NONE;
            shadow          <= '0;
            start_cnt       <= '0;
            evt_cnt         <= '0;
            o_fclk_div      <= FCLK_DIV_BITS'(1);
            o_num           <= '0;
            o_denom         <= '0;
            o_fclk_rst_cycs <= '0;
            o_vernier_start <= 1'b0;
            o_vernier_ready <= 1'b0;
            o_vernier_error <= 1'b0;
`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
            retry_cnt       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_LOCKED, ST_ERROR: begin
                    if (accept) begin
                        shadow          <= cfg_in;
                        state           <= ST_CHECK;
                        o_vernier_ready <= 1'b0;
                        o_vernier_error <= 1'b0;
                        err_code        <= ERR_NONE;
`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
                        if (state != ST_LOCKED) begin
                            retry_cnt <= '0;
                        end
`endif
                    end else if ((state == ST_LOCKED) && wd_timeout) begin
                        o_vernier_ready <= 1'b0;
`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
                        if (retry_cnt != RETRY_MAX) begin
                            retry_cnt       <= retry_cnt + 2'd1;
                            state           <= ST_START;
                            o_vernier_start <= 1'b1;
                            start_cnt       <= START_LOAD;
                        end else begin
                            state           <= ST_ERROR;
                            o_vernier_error <= 1'b1;
                            err_code        <= ERR_LOST;
                        end
`else
                        state           <= ST_ERROR;
                        o_vernier_error <= 1'b1;
                        err_code        <= ERR_LOST;
`endif
                    end
                end

                ST_CHECK: begin
                    if (tsu_cfg_valid(shadow)) begin
                        o_fclk_div      <= shadow.fclk_div;
                        o_num           <= shadow.num;
                        o_denom         <= shadow.denom;
                        o_fclk_rst_cycs <= shadow.timeout;
                        o_vernier_start <= 1'b1;
                        start_cnt       <= START_LOAD;
                        state           <= ST_START;
                    end else begin
                        o_vernier_error <= 1'b1;
                        err_code        <= ERR_CFG;
                        state           <= ST_ERROR;
                    end
                end

                ST_START: begin
                    if (start_cnt == '0) begin
                        o_vernier_start <= 1'b0;
                        evt_cnt         <= '0;
                        state           <= ST_SETTLE;
                    end else begin
                        start_cnt <= start_cnt - SC_ONE;
                    end
                end

                ST_SETTLE: begin
                    if (i_evt) begin
                        evt_cnt <= evt_cnt + EV_ONE;
                        if (evt_cnt == EVT_LAST) begin
                            o_vernier_ready <= 1'b1;
                            state           <= ST_LOCKED;
`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
                            retry_cnt       <= '0;
`endif
                        end
                    end else if (wd_timeout) begin
`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
                        // A settle timeout during a retry is another lost clock,
                        // not a settle failure.
                        if (retry_cnt == '0) begin
                            o_vernier_error <= 1'b1;
                            err_code        <= ERR_SETTLE;
                            state           <= ST_ERROR;
                        end else if (retry_cnt != RETRY_MAX) begin
                            retry_cnt       <= retry_cnt + 2'd1;
                            o_vernier_start <= 1'b1;
                            start_cnt       <= START_LOAD;
                            state           <= ST_START;
                        end else begin
                            o_vernier_error <= 1'b1;
                            err_code        <= ERR_LOST;
                            state           <= ST_ERROR;
                        end
`else
                        o_vernier_error <= 1'b1;
                        err_code        <= ERR_SETTLE;
                        state           <= ST_ERROR;
`endif
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tsu_vernier_ctrl.sv
// Directed bench for tsu_vernier_ctrl with hand-computed cycle expectations.
module tb_tsu_vernier_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic        o_cfg_ready;
    logic [2:0]  i_cfg_fclk_div = '0;
    logic [31:0] i_cfg_num = '0;
    logic [31:0] i_cfg_denom = '0;
    logic [15:0] i_cfg_timeout = '0;
    logic        i_evt = 1'b0;
    logic [2:0]  o_fclk_div;
    logic [31:0] o_num;
    logic [31:0] o_denom;
    logic [15:0] o_fclk_rst_cycs;
    logic        o_vernier_start;
    logic        o_vernier_ready;
    logic        o_vernier_error;
    logic [1:0]  o_err_code;

    int checks = 0;
    int failures = 0;
    int start_hi = 0;
    int ready_seen = 0;

    logic [2:0]  bad_div [0:4] = '{3'd0, 3'd4, 3'd4, 3'd4, 3'd5};
    logic [31:0] bad_num [0:4] = '{32'd8, 32'd0, 32'd8, 32'd8, 32'd8};
    logic [31:0] bad_den [0:4] = '{32'd5, 32'd5, 32'd0, 32'd5, 32'd5};
    logic [15:0] bad_to  [0:4] = '{16'd100, 16'd100, 16'd100, 16'd1, 16'd100};

    tsu_vernier_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cfg_valid     (i_cfg_valid),
        .o_cfg_ready     (o_cfg_ready),
        .i_cfg_fclk_div  (i_cfg_fclk_div),
        .i_cfg_num       (i_cfg_num),
        .i_cfg_denom     (i_cfg_denom),
        .i_cfg_timeout   (i_cfg_timeout),
        .i_evt           (i_evt),
        .o_fclk_div      (o_fclk_div),
        .o_num           (o_num),
        .o_denom         (o_denom),
        .o_fclk_rst_cycs (o_fclk_rst_cycs),
        .o_vernier_start (o_vernier_start),
        .o_vernier_ready (o_vernier_ready),
        .o_vernier_error (o_vernier_error),
        .o_err_code      (o_err_code)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (o_vernier_start) start_hi++;
            if (o_vernier_ready) ready_seen++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_cfg_valid = 1'b0;
        i_evt = 1'b0;
        step(2);
        rst_n = 1'b1;
        start_hi = 0;
        ready_seen = 0;
    endtask

    task automatic send_cfg(input logic [2:0] div, input logic [31:0] num,
                            input logic [31:0] den, input logic [15:0] to);
        i_cfg_fclk_div = div;
        i_cfg_num      = num;
        i_cfg_denom    = den;
        i_cfg_timeout  = to;
        i_cfg_valid    = 1'b1;
        step(1);
        i_cfg_valid    = 1'b0;
    endtask

    task automatic pulse_evt();
        i_evt = 1'b1;
        step(1);
        i_evt = 1'b0;
    endtask

    task automatic lock_cfg(input logic [15:0] to, input int gap);
        send_cfg(3'd2, 32'd3, 32'd7, to);
        step(3);
        for (int k = 0; k < 4; k++) begin
            step(gap);
            pulse_evt();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_cfg_ready, o_vernier_start, o_vernier_ready, o_vernier_error, o_err_code} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_status: got rdy/st/rd/er/code=%b want 100000",
                     {o_cfg_ready, o_vernier_start, o_vernier_ready, o_vernier_error, o_err_code});
        end
        checks++;
        if ({o_fclk_div, o_num, o_denom, o_fclk_rst_cycs} !== {3'd1, 32'd0, 32'd0, 16'd0}) begin
            failures++;
            $display("FAIL reset_tsu_outs: got div=%0d num=%0d den=%0d to=%0d want 1 0 0 0",
                     o_fclk_div, o_num, o_denom, o_fclk_rst_cycs);
        end
    endtask

    task automatic test_bad_config();
        do_reset();
        send_cfg(3'd3, 32'd8, 32'd5, 16'd100);
        step(1);
        checks++;
        if ({o_vernier_error, o_err_code, o_fclk_div} !== {1'b1, 2'd1, 3'd1} || start_hi != 0) begin
            failures++;
            $display("FAIL bad_div3: got err=%b code=%0d div=%0d starts=%0d want 1 1 1 0",
                     o_vernier_error, o_err_code, o_fclk_div, start_hi);
        end
        for (int v = 0; v < 5; v++) begin
            send_cfg(bad_div[v], bad_num[v], bad_den[v], bad_to[v]);
            checks++;
            if ({o_vernier_error, o_err_code} !== 3'b000) begin
                failures++;
                $display("FAIL bad_accept_clear[%0d]: got err=%b code=%0d want 0 0", v, o_vernier_error, o_err_code);
            end
            step(1);
            checks++;
            if ({o_vernier_error, o_err_code} !== {1'b1, 2'd1} || start_hi != 0) begin
                failures++;
                $display("FAIL bad_vec[%0d]: got err=%b code=%0d starts=%0d want 1 1 0",
                         v, o_vernier_error, o_err_code, start_hi);
            end
        end
    endtask

    task automatic test_good_config();
        do_reset();
        send_cfg(3'd4, 32'd8, 32'd5, 16'd100);
        checks++;
        if (o_vernier_start !== 1'b0 || o_fclk_div !== 3'd1) begin
            failures++;
            $display("FAIL good_check_cycle: got start=%b div=%0d want 0 1", o_vernier_start, o_fclk_div);
        end
        step(1);
        checks++;
        if ({o_vernier_start, o_cfg_ready, o_fclk_div, o_num, o_denom, o_fclk_rst_cycs} !==
            {1'b1, 1'b0, 3'd4, 32'd8, 32'd5, 16'd100}) begin
            failures++;
            $display("FAIL good_start: got st=%b rdy=%b div=%0d num=%0d den=%0d to=%0d want 1 0 4 8 5 100",
                     o_vernier_start, o_cfg_ready, o_fclk_div, o_num, o_denom, o_fclk_rst_cycs);
        end
        step(2);
        checks++;
        if (o_vernier_start !== 1'b0 || start_hi != 2 || o_cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL good_start_len: got st=%b cycles=%0d cfg_rdy=%b want 0 2 0",
                     o_vernier_start, start_hi, o_cfg_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            step(19);
            if (k == 4) begin
                checks++;
                if (o_vernier_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL good_ready_early: got %b want 0", o_vernier_ready);
                end
            end
            pulse_evt();
        end
        checks++;
        if ({o_vernier_ready, o_vernier_error, o_err_code, o_cfg_ready} !== 5'b10001) begin
            failures++;
            $display("FAIL good_locked: got rd=%b er=%b code=%0d cfg_rdy=%b want 1 0 0 1",
                     o_vernier_ready, o_vernier_error, o_err_code, o_cfg_ready);
        end
    endtask

    // Continues from LOCKED left by test_good_config.
    task automatic test_reconfig_and_loss();
        send_cfg(3'd2, 32'd3, 32'd7, 16'd50);
        checks++;
        if (o_vernier_ready !== 1'b0 || o_fclk_div !== 3'd4 || o_fclk_rst_cycs !== 16'd100) begin
            failures++;
            $display("FAIL reconfig_hold: got rd=%b div=%0d to=%0d want 0 4 100",
                     o_vernier_ready, o_fclk_div, o_fclk_rst_cycs);
        end
        step(1);
        checks++;
        if (o_fclk_div !== 3'd2 || o_vernier_start !== 1'b1) begin
            failures++;
            $display("FAIL reconfig_apply: got div=%0d st=%b want 2 1", o_fclk_div, o_vernier_start);
        end
        step(2);
        for (int k = 0; k < 4; k++) begin
            step(9);
            pulse_evt();
        end
        step(49);
        checks++;
        if (o_vernier_ready !== 1'b1 || o_vernier_error !== 1'b0) begin
            failures++;
            $display("FAIL loss_early: got rd=%b er=%b want 1 0", o_vernier_ready, o_vernier_error);
        end
        step(1);
        checks++;
`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
        if ({o_vernier_ready, o_vernier_error, o_vernier_start} !== 3'b001) begin
            failures++;
            $display("FAIL loss_restart: got rd=%b er=%b st=%b want 0 0 1",
                     o_vernier_ready, o_vernier_error, o_vernier_start);
        end
`else
        if ({o_vernier_ready, o_vernier_error, o_err_code} !== {1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL loss_at_50: got rd=%b er=%b code=%0d want 0 1 2",
                     o_vernier_ready, o_vernier_error, o_err_code);
        end
`endif
    endtask

    task automatic test_timeout_tie();
        do_reset();
        lock_cfg(16'd50, 9);
        step(49);
        i_evt = 1'b1;
        step(1);
        i_evt = 1'b0;
        checks++;
        if (o_vernier_ready !== 1'b1 || o_vernier_error !== 1'b0) begin
            failures++;
            $display("FAIL tie_stays_locked: got rd=%b er=%b want 1 0", o_vernier_ready, o_vernier_error);
        end
        step(49);
        checks++;
        if (o_vernier_ready !== 1'b1 || o_vernier_error !== 1'b0) begin
            failures++;
            $display("FAIL tie_age_cleared: got rd=%b er=%b want 1 0", o_vernier_ready, o_vernier_error);
        end
        step(1);
        checks++;
        if (o_vernier_ready !== 1'b0) begin
            failures++;
            $display("FAIL tie_later_loss: got rd=%b want 0", o_vernier_ready);
        end
    endtask

    task automatic test_settle_timeout();
        do_reset();
        send_cfg(3'd4, 32'd8, 32'd5, 16'd30);
        step(3);
        step(5);
        pulse_evt();
        step(5);
        pulse_evt();
        step(29);
        checks++;
        if (o_vernier_error !== 1'b0) begin
            failures++;
            $display("FAIL settle_early: got er=%b want 0", o_vernier_error);
        end
        step(1);
        checks++;
        if ({o_vernier_error, o_err_code} !== {1'b1, 2'd3} || ready_seen != 0) begin
            failures++;
            $display("FAIL settle_timeout: got er=%b code=%0d ready_cycles=%0d want 1 3 0",
                     o_vernier_error, o_err_code, ready_seen);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        send_cfg(3'd1, 32'd1, 32'd1, 16'd2);
        step(1);
        checks++;
        if (o_vernier_start !== 1'b1 || o_vernier_error !== 1'b0) begin
            failures++;
            $display("FAIL bnd_div1_to2: got st=%b er=%b want 1 0", o_vernier_start, o_vernier_error);
        end
        step(2);
        step(1);
        checks++;
        if (o_vernier_error !== 1'b0) begin
            failures++;
            $display("FAIL bnd_to2_early: got er=%b want 0", o_vernier_error);
        end
        step(1);
        checks++;
        if ({o_vernier_error, o_err_code} !== {1'b1, 2'd3}) begin
            failures++;
            $display("FAIL bnd_to2_expire: got er=%b code=%0d want 1 3", o_vernier_error, o_err_code);
        end
        send_cfg(3'd6, 32'd1, 32'd1, 16'd2);
        step(1);
        checks++;
        if (o_vernier_start !== 1'b1 || o_fclk_div !== 3'd6) begin
            failures++;
            $display("FAIL bnd_div6: got st=%b div=%0d want 1 6", o_vernier_start, o_fclk_div);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_cfg(3'd4, 32'd8, 32'd5, 16'd100);
        step(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_vernier_start, o_cfg_ready, o_fclk_div} !== {1'b0, 1'b1, 3'd1}) begin
            failures++;
            $display("FAIL reset_mid: got st=%b rdy=%b div=%0d want 0 1 1",
                     o_vernier_start, o_cfg_ready, o_fclk_div);
        end
        rst_n = 1'b1;
        step(1);
    endtask

`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
    task automatic test_autorestart();
        do_reset();
        lock_cfg(16'd30, 4);
        start_hi = 0;
        for (int i = 0; i < 400 && !o_vernier_error; i++) step(1);
        checks++;
        if ({o_vernier_error, o_err_code} !== {1'b1, 2'd2} || start_hi != 4) begin
            failures++;
            $display("FAIL ar_three_losses: got er=%b code=%0d start_cycles=%0d want 1 2 4",
                     o_vernier_error, o_err_code, start_hi);
        end
        do_reset();
        lock_cfg(16'd30, 4);
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 200 && !o_vernier_start; i++) step(1);
            checks++;
            if (o_vernier_start !== 1'b1 || o_vernier_error !== 1'b0) begin
                failures++;
                $display("FAIL ar_relock_restart[%0d]: got st=%b er=%b want 1 0", n, o_vernier_start, o_vernier_error);
            end
            step(2);
            for (int k = 0; k < 4; k++) begin
                step(4);
                pulse_evt();
            end
            checks++;
            if (o_vernier_ready !== 1'b1) begin
                failures++;
                $display("FAIL ar_relock[%0d]: got rd=%b want 1", n, o_vernier_ready);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bad_config();
        test_good_config();
        test_reconfig_and_loss();
        test_timeout_tie();
        test_settle_timeout();
        test_boundary();
        test_reset_mid();
`ifdef TSU_VERNIER_CTRL_AUTORESTART_EN
        test_autorestart();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tsu_vernier_ctrl.md
Name: tsu_vernier_ctrl

Overview:
- Sequencer for one vernier timestamp unit (tsu).
- Accepts a configuration request and validates it.
- Holds the TSU's rate and divider inputs stable, issues the vernier start pulse, then waits until enough foreign-clock events have arrived to treat the phase tracking as settled.
- Drives ready/error status and watches for loss of the foreign clock while locked.

Parameters:
- FCLK_DIV_BITS, 3, width of foreign-clock divider field
- FCLK_RST_BITS, 16, width of event-timeout/cycle counters
- RAT_PREC_BITS, 32, width of num/denom rational period fields
- SETTLE_EVTS, 4, consecutive in-time events required before ready
- START_CYCS, 2, clk cycles the start pulse is held

Ports:
- clk  in  1  1588 clock
- rst_n  in  1  asynchronous active-low reset
- i_cfg_valid  in  1  configuration request
- o_cfg_ready  out  1  controller accepts configuration (IDLE, LOCKED or ERROR)
- i_cfg_fclk_div  in  FCLK_DIV_BITS  requested foreign-clock divider
- i_cfg_num  in  RAT_PREC_BITS  1588 period
- i_cfg_denom  in  RAT_PREC_BITS  foreign-clock period
- i_cfg_timeout  in  FCLK_RST_BITS  max clk cycles between events
- i_evt  in  1  synchronized foreign-clock event pulse from TSU
- o_fclk_div  out  FCLK_DIV_BITS  registered divider to TSU
- o_num  out  RAT_PREC_BITS  registered num to TSU
- o_denom  out  RAT_PREC_BITS  registered denom to TSU
- o_fclk_rst_cycs  out  FCLK_RST_BITS  registered timeout to TSU
- o_vernier_start  out  1  TSU start / min-max reset
- o_vernier_ready  out  1  TSU settled; timestamps valid
- o_vernier_error  out  1  sticky error flag
- o_err_code  out  2  0 none, 1 bad config, 2 clock lost, 3 settle timeout

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - state IDLE; all o_* registers 0
  - o_cfg_ready=1 (combinational from state)
  - o_fclk_div=1
- States: IDLE, CHECK, START, SETTLE, LOCKED, ERROR.
- Accept: i_cfg_valid & o_cfg_ready captures all i_cfg_* into shadow registers in that cycle, then enters CHECK next cycle.
  - The accept clears ready, error and err_code in that same cycle.
  - A valid request while in SETTLE or START is held off (o_cfg_ready=0).
- CHECK (1 cycle): the config is valid iff all of:
  - fclk_div==1, or fclk_div is even and nonzero
  - num!=0
  - denom!=0
  - timeout>=2
  - Valid: copy shadow to o_* and go to START. Invalid: o_* unchanged, go to ERROR with code 1.
- START:
  - o_vernier_start=1 for exactly START_CYCS cycles, counted from the first START cycle.
  - i_evt is ignored during START.
  - Then enter SETTLE with evt_cnt=0 and age=0.
- Age counter:
  - Resets to 0 on i_evt; otherwise increments.
  - Saturates at all-ones and never wraps.
- SETTLE:
  - Each i_evt increments evt_cnt.
  - When evt_cnt reaches SETTLE_EVTS (the SETTLE_EVTS-th event), go to LOCKED and set o_vernier_ready the next cycle.
  - If age reaches o_fclk_rst_cycs before that, go to ERROR with code 3.
- LOCKED:
  - o_vernier_ready=1.
  - If age reaches o_fclk_rst_cycs, go to ERROR with code 2 (or restart, see Optional Feature); ready drops in the same transition.
- ERROR:
  - o_vernier_error=1 and o_err_code held until the next accepted configuration.
  - The TSU outputs keep their last values.
- Timeout tie: if i_evt arrives in the same cycle age==timeout, the event wins and the age clears.
- Reconfigure from LOCKED: accept goes to CHECK. Ready drops the cycle after the accept; o_* keep their old values until CHECK passes.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The start pulse is cut.
- Arithmetic: all counters unsigned and saturating. No modular compare is needed in this block.

Optional Feature:
- Macro: TSU_VERNIER_CTRL_AUTORESTART_EN.
- With the macro defined: a clock loss in LOCKED goes to START (re-pulse) instead of ERROR.
  - A 2-bit retry counter increments on each restart; a third consecutive loss goes to ERROR with code 2.
  - The retry counter clears on entry to LOCKED, and on accept only when that accept is not from LOCKED (i.e., from IDLE or ERROR).
- Without the macro: clock loss always goes to ERROR; no retry counter exists.

Decomposition:
- Package tsu_ctrl_pkg holds:
  - state enum (tsu_ctrl_state_e)
  - err_code enum (tsu_err_e: ERR_NONE, ERR_CFG, ERR_LOST, ERR_SETTLE)
  - packed config struct (tsu_cfg_t: fclk_div, num, denom, timeout)
  - default widths
- Sub-module tsu_evt_watchdog holds the age counter and the timeout compare, and outputs a one-cycle timeout pulse.

Test Plan:
- Good config (div=4, num=8, denom=5, timeout=100), events every 20 cycles -> start high 2 cycles; ready rises 1 cycle after the 4th event; err_code=0.
- Bad config (div=3) -> ERROR 2 cycles after accept; error=1, code=1; o_fclk_div stays 1; no start pulse.
- Locked, then events stop (timeout=50) -> ready falls and error=1, code=2 exactly 50 cycles after the last event.
- SETTLE with only 2 events then silence (timeout=30) -> code=3; ready never asserts.
- Event coincident with age==timeout while LOCKED -> stays LOCKED; age clears; no error.
- With AUTORESTART_EN: three clock losses with no lock in between -> 2 start pulses, then ERROR code 2. A relock between losses resets the retry count.
